// File: rtl/ex_dm_pipe_reg.sv
// rtl/ex_dm_pipe_reg.sv - EX->DM pipeline register with sub-word store alignment
//
// Purpose: registers the EX stage into the DM stage with valid/bubble tracking,
// stall (hold), flush (bubble insert), store-lane replication with byte enables,
// access-misalignment trap and an EX-forwarding tap.
//
// Ports:
//   clk, reset                  rising-edge clock, async active-high reset
//   stall, flush                hold stage / replace stage with a bubble
//   valid_in                    EX stage holds a real instruction
//   alu_result_in               effective address / ALU result
//   write_data_in               right-justified store data
//   rd_in, mem_size_in          destination register, access size (B/H/W/D)
//   mem_read_in .. reg_write_in control bits
//   valid_out .. rd_out         registered stage contents
//   byte_en_out                 per-lane store enables
//   misaligned_out              registered alignment fault
//   fwd_valid/fwd_rd/fwd_data   forwarding tap
//   stall_cycles                saturating stalled-cycle counter
module ex_dm_pipe_reg #(
  parameter int DATA_W      = 32,
  parameter int RD_W        = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   valid_in,
  input  logic [DATA_W-1:0]      alu_result_in,
  input  logic [DATA_W-1:0]      write_data_in,
  input  logic [RD_W-1:0]        rd_in,
  input  logic [1:0]             mem_size_in,
  input  logic                   mem_read_in,
  input  logic                   mem_write_in,
  input  logic                   mem_to_reg_in,
  input  logic                   reg_write_in,
  output logic                   valid_out,
  output logic [DATA_W-1:0]      mem_address_out,
  output logic [DATA_W-1:0]      write_data_out,
  output logic [DATA_W/8-1:0]    byte_en_out,
  output logic                   mem_read_out,
  output logic                   mem_write_out,
  output logic                   mem_to_reg_out,
  output logic                   reg_write_out,
  output logic [RD_W-1:0]        rd_out,
  output logic                   misaligned_out,
  output logic                   fwd_valid,
  output logic [RD_W-1:0]        fwd_rd,
  output logic [DATA_W-1:0]      fwd_data,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int L     = DATA_W / 8;
  localparam int OFF_W = $clog2(L);
  localparam bit IS_32 = (DATA_W == 32);

  logic [OFF_W-1:0]       w_offset;
  logic [2:0]             w_size_mask;   // access bytes minus one
  logic [7:0]             w_lane_mask;   // one bit per accessed byte, right-justified
  logic                   w_size_bad;
  logic                   w_misaligned;
  logic                   w_keep;
  logic [L-1:0]           w_byte_en;
  logic [DATA_W-1:0]      w_wd_rep;

  logic                   r_valid;
  logic [DATA_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic [L-1:0]           r_byte_en;
  logic                   r_mem_read;
  logic                   r_mem_write;
  logic                   r_mem_to_reg;
  logic                   r_reg_write;
  logic [RD_W-1:0]        r_rd;
  logic                   r_misaligned;
  logic [STALL_CNT_W-1:0] r_stall_cycles;

  assign w_offset = alu_result_in[OFF_W-1:0];

  always_comb begin
    w_size_mask = 3'd0;
    w_lane_mask = 8'h01;
    case (mem_size_in)
      2'b00:   begin w_size_mask = 3'd0; w_lane_mask = 8'h01; end
      2'b01:   begin w_size_mask = 3'd1; w_lane_mask = 8'h03; end
      2'b10:   begin w_size_mask = 3'd3; w_lane_mask = 8'h0F; end
      default: begin w_size_mask = 3'd7; w_lane_mask = 8'hFF; end
    endcase
  end

  // A doubleword access cannot be carried on a 32-bit datapath at all.
  assign w_size_bad   = IS_32 && (mem_size_in == 2'b11);
  assign w_misaligned = (mem_read_in | mem_write_in) & valid_in &
                        ((|(w_offset & w_size_mask[OFF_W-1:0])) | w_size_bad);
  assign w_keep       = valid_in & ~w_misaligned;
  assign w_byte_en    = (mem_write_in & w_keep) ? (w_lane_mask[L-1:0] << w_offset) : '0;

  // Lane i carries byte (i mod N) of the store data, so every aligned slot sees it.
  always_comb begin
    w_wd_rep = '0;
    if (!w_size_bad) begin
      for (int i = 0; i < L; i++) begin
        w_wd_rep[i*8 +: 8] = write_data_in[(i & int'(w_size_mask))*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid        <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_byte_en      <= '0;
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b0;
      r_mem_to_reg   <= 1'b0;
      r_reg_write    <= 1'b0;
      r_rd           <= '0;
      r_misaligned   <= 1'b0;
      r_stall_cycles <= '0;
    end else if (flush) begin
      // Bubble: kill everything that has side effects, leave data/rd as-is.
      r_valid      <= 1'b0;
      r_byte_en    <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
      r_misaligned <= 1'b0;
    end else if (stall) begin
      if (r_stall_cycles != '1) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
    end else begin
      r_valid      <= valid_in;
      r_addr       <= alu_result_in;
      r_wdata      <= w_wd_rep;
      r_byte_en    <= w_byte_en;
      r_mem_read   <= mem_read_in & w_keep;
      r_mem_write  <= mem_write_in & w_keep;
      r_mem_to_reg <= mem_to_reg_in & valid_in;
      r_reg_write  <= reg_write_in & w_keep;
      r_rd         <= rd_in;
      r_misaligned <= w_misaligned;
    end
  end

  assign valid_out       = r_valid;
  assign mem_address_out = r_addr;
  assign write_data_out  = r_wdata;
  assign byte_en_out     = r_byte_en;
  assign mem_read_out    = r_mem_read;
  assign mem_write_out   = r_mem_write;
  assign mem_to_reg_out  = r_mem_to_reg;
  assign reg_write_out   = r_reg_write;
  assign rd_out          = r_rd;
  assign misaligned_out  = r_misaligned;
  assign stall_cycles    = r_stall_cycles;

  // Loads produce their value only in DM, so they cannot be forwarded from here.
  assign fwd_valid = r_valid & r_reg_write & ~r_mem_to_reg & (r_rd != '0);
  assign fwd_rd    = r_rd;
  assign fwd_data  = r_addr;

endmodule

// File: tb/tb_ex_dm_pipe_reg.sv
// tb/tb_ex_dm_pipe_reg.sv - self-checking bench for ex_dm_pipe_reg
module tb_ex_dm_pipe_reg;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, valid_in;
  logic [31:0] alu_result_in, write_data_in;
  logic [4:0]  rd_in;
  logic [1:0]  mem_size_in;
  logic        mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in;
  logic        valid_out;
  logic [31:0] mem_address_out, write_data_out;
  logic [3:0]  byte_en_out;
  logic        mem_read_out, mem_write_out, mem_to_reg_out, reg_write_out;
  logic [4:0]  rd_out;
  logic        misaligned_out, fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic        e_valid, e_mr, e_mw, e_mtr, e_rw, e_mis;
  logic [31:0] e_addr, e_wd;
  logic [3:0]  e_be;
  logic [4:0]  e_rd;
  int          e_cnt;

  ex_dm_pipe_reg #(.DATA_W(32), .RD_W(5), .STALL_CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .alu_result_in(alu_result_in), .write_data_in(write_data_in), .rd_in(rd_in),
    .mem_size_in(mem_size_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
    .valid_out(valid_out), .mem_address_out(mem_address_out),
    .write_data_out(write_data_out), .byte_en_out(byte_en_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out), .rd_out(rd_out),
    .misaligned_out(misaligned_out), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_valid = 0; e_mr = 0; e_mw = 0; e_mtr = 0; e_rw = 0; e_mis = 0;
    e_addr = 0; e_wd = 0; e_be = 0; e_rd = 0; e_cnt = 0;
  endtask

  task automatic check_all(input string where);
    logic exp_fwd;
    exp_fwd = e_valid && e_rw && !e_mtr && (e_rd != 0);
    check({where, ".valid"}, 64'(valid_out), 64'(e_valid));
    check({where, ".addr"},  64'(mem_address_out), 64'(e_addr));
    check({where, ".wd"},    64'(write_data_out), 64'(e_wd));
    check({where, ".be"},    64'(byte_en_out), 64'(e_be));
    check({where, ".mr"},    64'(mem_read_out), 64'(e_mr));
    check({where, ".mw"},    64'(mem_write_out), 64'(e_mw));
    check({where, ".mtr"},   64'(mem_to_reg_out), 64'(e_mtr));
    check({where, ".rw"},    64'(reg_write_out), 64'(e_rw));
    check({where, ".rd"},    64'(rd_out), 64'(e_rd));
    check({where, ".mis"},   64'(misaligned_out), 64'(e_mis));
    check({where, ".fwdv"},  64'(fwd_valid), 64'(exp_fwd));
    check({where, ".fwdrd"}, 64'(fwd_rd), 64'(e_rd));
    check({where, ".fwdd"},  64'(fwd_data), 64'(e_addr));
    check({where, ".cnt"},   64'(stall_cycles), 64'(e_cnt));
  endtask

  // One clock: drive inputs, advance the model by the stated rules, check after the edge.
  task automatic step(input string where, input logic st, input logic fl, input logic v,
                      input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                      input logic [1:0] sz, input logic mr, input logic mw,
                      input logic mtr, input logic rw);
    int n, off;
    logic mis;
    logic [31:0] rep, span;
    stall = st; flush = fl; valid_in = v; alu_result_in = a; write_data_in = wd;
    rd_in = rd; mem_size_in = sz; mem_read_in = mr; mem_write_in = mw;
    mem_to_reg_in = mtr; reg_write_in = rw;
    if (fl) begin
      e_valid = 0; e_mr = 0; e_mw = 0; e_mtr = 0; e_rw = 0; e_be = 0; e_mis = 0;
    end else if (st) begin
      if (e_cnt < (1 << CW) - 1) e_cnt++;
    end else begin
      n = 1 << sz;
      off = a % 4;
      mis = (mr || mw) && v && ((off % n) != 0 || n > 4);
      rep = 0;
      if (n <= 4)
        for (int b = 0; b < 4; b++) rep = rep | (((wd >> (8 * (b % n))) & 32'hFF) << (8 * b));
      span = ((32'd1 << n) - 1) << off;
      e_valid = v; e_addr = a; e_rd = rd; e_wd = rep; e_mis = mis;
      e_be  = (mw && v && !mis) ? span[3:0] : 4'h0;
      e_mr  = mr && v && !mis;
      e_mw  = mw && v && !mis;
      e_rw  = rw && v && !mis;
      e_mtr = mtr && v;
    end
    @(posedge clk);
    #1;
    check_all(where);
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0; valid_in = 0; alu_result_in = 0; write_data_in = 0;
    rd_in = 0; mem_size_in = 0; mem_read_in = 0; mem_write_in = 0; mem_to_reg_in = 0;
    reg_write_in = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("rst0");
    reset = 0;

    // sw aligned
    step("sw", 0, 0, 1, 32'h1004, 32'hDEADBEEF, 5'd0, 2'b10, 0, 1, 0, 0);
    check("sw.be_k", 64'(byte_en_out), 64'hF);
    check("sw.wd_k", 64'(write_data_out), 64'hDEADBEEF);
    // sb top lane
    step("sb", 0, 0, 1, 32'h1003, 32'h000000A5, 5'd0, 2'b00, 0, 1, 0, 0);
    check("sb.be_k", 64'(byte_en_out), 64'h8);
    check("sb.wd_k", 64'(write_data_out), 64'hA5A5A5A5);
    check("sb.mis_k", 64'(misaligned_out), 64'h0);
    // sh misaligned
    step("sh", 0, 0, 1, 32'h1001, 32'h00001234, 5'd0, 2'b01, 0, 1, 0, 0);
    check("sh.mis_k", 64'(misaligned_out), 64'h1);
    check("sh.mw_k", 64'(mem_write_out), 64'h0);
    check("sh.be_k", 64'(byte_en_out), 64'h0);
    check("sh.addr_k", 64'(mem_address_out), 64'h1001);
    // doubleword on 32-bit path always traps
    step("ld64", 0, 0, 1, 32'h2000, 32'h0, 5'd3, 2'b11, 1, 0, 1, 1);
    check("ld64.mis_k", 64'(misaligned_out), 64'h1);

    // forwarding tap
    step("add7", 0, 0, 1, 32'h0000_5A5A, 32'h0, 5'd7, 2'b10, 0, 0, 0, 1);
    check("add7.fwd_k", 64'(fwd_valid), 64'h1);
    check("add7.fwdd_k", 64'(fwd_data), 64'h5A5A);
    step("lw7", 0, 0, 1, 32'h0000_0040, 32'h0, 5'd7, 2'b10, 1, 0, 1, 1);
    check("lw7.fwd_k", 64'(fwd_valid), 64'h0);
    step("add0", 0, 0, 1, 32'h0000_0123, 32'h0, 5'd0, 2'b10, 0, 0, 0, 1);
    check("add0.fwd_k", 64'(fwd_valid), 64'h0);
    step("bub", 0, 0, 0, 32'h0000_0044, 32'h77, 5'd9, 2'b10, 1, 1, 1, 1);
    check("bub.ctl_k", 64'({valid_out, mem_read_out, mem_write_out, mem_to_reg_out, reg_write_out}), 64'h0);

    // reset mid-stall: asynchronous, wins over the clock edge
    step("pre", 0, 0, 1, 32'h0000_0108, 32'hCAFEF00D, 5'd4, 2'b10, 0, 1, 0, 1);
    step("st1", 1, 0, 1, 32'h0, 32'h0, 5'd0, 2'b00, 0, 0, 0, 0);
    #2 reset = 1;
    model_reset();
    #1 check_all("arst");
    check("arst.fwd_k", 64'(fwd_valid), 64'h0);
    stall = 1; flush = 1;
    @(posedge clk);
    #1 check_all("arst_edge");
    reset = 0;
    step("post", 0, 0, 1, 32'h0000_0200, 32'h11223344, 5'd5, 2'b10, 0, 1, 0, 1);

    // stall three cycles then stall+flush
    for (int i = 0; i < 3; i++)
      step("hold", 1, 0, 1, $urandom, $urandom, 5'd9, 2'b00, 1, 1, 1, 1);
    step("sflush", 1, 1, 1, $urandom, $urandom, 5'd9, 2'b00, 1, 1, 1, 1);
    check("sflush.valid_k", 64'(valid_out), 64'h0);
    check("sflush.cnt_k", 64'(stall_cycles), 64'd3);

    // counter saturation
    for (int i = 0; i < 20; i++)
      step("sat", 1, 0, 0, 32'h0, 32'h0, 5'd0, 2'b00, 0, 0, 0, 0);
    check("sat.cnt_k", 64'(stall_cycles), 64'd15);
    step("flush_keep", 0, 1, 1, 32'h0, 32'h0, 5'd1, 2'b00, 0, 0, 0, 1);
    check("flush_keep.cnt_k", 64'(stall_cycles), 64'd15);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic r_mr, r_mw;
      r_mr = ($urandom % 3) == 0;
      r_mw = !r_mr && (($urandom % 2) == 0);
      step("rnd", ($urandom % 6) == 0, ($urandom % 9) == 0, ($urandom % 4) != 0,
           $urandom, $urandom, 5'($urandom), 2'($urandom), r_mr, r_mw,
           1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
